ps2_kbd_tx: RTL and testbench



---
 rtl/ps2_kbd_tx.sv | 179 +++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: scan codes are queued in a FIFO and sent as 11-bit frames.
// Define PS2_TX_INHIBIT_EN to add the host_inhibit input (frame abort with retransmission).
module ps2_kbd_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
`ifdef PS2_TX_INHIBIT_EN
    input  logic       host_inhibit,
`endif
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntMax = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [PtrW:0]   DepthVal = FIFO_DEPTH[PtrW:0];
    localparam logic [CntW-1:0] HalfVal  = CntW'(CLK_DIV);
    localparam logic [CntW-1:0] BitLast  = CntW'(2 * CLK_DIV - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            retry_q, retry_d;
    logic            ps2_clk_q, ps2_clk_d;
    logic            ps2_data_q, ps2_data_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];

    logic full, empty, push, pop, inhibit;

`ifdef PS2_TX_INHIBIT_EN
    assign inhibit = host_inhibit;
`else
    assign inhibit = 1'b0;
`endif

    // Wire order: start 0, data LSB first, odd parity, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        if (idx == 4'd0) begin
            return 1'b0;
        end else if (idx <= 4'd8) begin
            return b[idx[2:0] - 3'd1];
        end else if (idx == 4'd9) begin
            return ~^b;
        end
        return 1'b1;
    endfunction

    assign full       = (count_q == DepthVal);
    assign empty      = (count_q == '0);
    assign push       = data_valid && !full;
    assign data_ready = !full;
    assign busy       = (state_q != StIdle) || !empty || retry_q;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        tx_byte_d  = tx_byte_q;
        retry_d    = retry_q;
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!inhibit && (retry_q || !empty)) begin
                    state_d    = StSend;
                    cnt_d      = '0;
                    bit_idx_d  = 4'd0;
                    ps2_data_d = 1'b0;
                    if (retry_q) begin
                        retry_d = 1'b0;
                    end else begin
                        pop       = 1'b1;
                        tx_byte_d = mem_q[rd_ptr_q];
                    end
                end
            end
            StSend: begin
                // Abort is allowed until the parity bit's falling edge has been driven.
                if (inhibit && ((bit_idx_q < 4'd9) || (bit_idx_q == 4'd9 && cnt_q < HalfVal))) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    retry_d = 1'b1;
                end else if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd10) begin
                        state_d = StGap;
                    end else begin
                        bit_idx_d  = bit_idx_q + 4'd1;
                        ps2_data_d = frame_bit(tx_byte_q, bit_idx_q + 4'd1);
                    end
                end else begin
                    cnt_d      = cnt_q + CntW'(1);
                    ps2_data_d = frame_bit(tx_byte_q, bit_idx_q);
                    ps2_clk_d  = ((cnt_q + CntW'(1)) < HalfVal);
                end
            end
            StGap: begin
                if (inhibit) begin
                    cnt_d = '0;
                end else if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            tx_byte_q  <= 8'h00;
            retry_q    <= 1'b0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_byte_q  <= tx_byte_d;
            retry_q    <= retry_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a line monitor decodes frames off ps2_clk/ps2_data and the main
// sequence compares them with a byte-queue model of what was pushed.
module tb_ps2_kbd_tx;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 8;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, ps2_clk, ps2_data, busy;
`ifdef PS2_TX_INHIBIT_EN
    logic       host_inhibit = 1'b0;
`endif

    always #5 clk = ~clk;

    ps2_kbd_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
`ifdef PS2_TX_INHIBIT_EN
        .host_inhibit(host_inhibit),
`endif
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .busy        (busy)
    );

    typedef struct {
        logic [10:0] bits;
        int          start;
        int          last_fall;
        int          gap;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    frame_t     cur;
    int cyc = 0, nbits = 0, hi_run = 0, mon_starts = 0, timing_err = 0, stray = 0, aborts = 0;
    logic in_frame = 1'b0, prev_clk = 1'b1, prev_data = 1'b1;
    int n_assert = 0, n_fail = 0, pushed = 0, start_base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes frames from the wires only.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            in_frame  = 1'b0;
            nbits     = 0;
            hi_run    = 0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (ps2_clk && ps2_data) hi_run++;
            if (in_frame && hi_run > CLK_DIV) begin
                aborts++;
                in_frame = 1'b0;
                nbits    = 0;
            end
            if (!in_frame && ps2_clk && !ps2_data && prev_data) begin
                in_frame  = 1'b1;
                nbits     = 0;
                cur.bits  = '0;
                cur.start = cyc;
                cur.gap   = hi_run;
                mon_starts++;
            end
            if (prev_clk && !ps2_clk) begin
                if (!in_frame) begin
                    stray++;
                end else begin
                    if (cyc != cur.start + CLK_DIV + 2 * CLK_DIV * nbits) timing_err++;
                    cur.bits[nbits] = ps2_data;
                    nbits++;
                    if (nbits == 11) begin
                        cur.last_fall = cyc;
                        rx_q.push_back(cur);
                        in_frame = 1'b0;
                        nbits    = 0;
                    end
                end
            end
            if (!(ps2_clk && ps2_data)) hi_run = 0;
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected wire bits, index 0 first on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int          ones;
        logic [10:0] f;
        ones = 0;
        f    = '0;
        for (int i = 0; i < 8; i++) begin
            ones    += int'(b[i]);
            f[i + 1] = b[i];
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic int occ();
        return pushed - (mon_starts - start_base);
    endfunction

    task automatic push(input logic [7:0] b);
        logic rdy;
        int   guard;
        guard      = 0;
        data_in    = b;
        data_valid = 1'b1;
        do begin
            rdy = (occ() < FIFO_DEPTH);
            chk("data_ready", {31'd0, data_ready}, {31'd0, rdy});
            step();
            guard++;
        end while (!rdy && guard < 1000);
        chk("push_accepted", {31'd0, rdy}, 32'd1);
        if (rdy) begin
            exp_q.push_back(b);
            pushed++;
        end
        data_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        frame_t     f;
        logic [7:0] e;
        int         guard, last_fall;
        guard     = 0;
        last_fall = 0;
        while (rx_q.size() < exp_q.size() && guard < 5000) begin
            step();
            guard++;
        end
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_bits"}, {21'd0, f.bits}, {21'd0, model_frame(e)});
            chk({tag, "_len"}, f.last_fall - f.start + CLK_DIV, 22 * CLK_DIV);
            chk({tag, "_gap"}, {31'd0, f.gap >= GAP_CYCLES}, 32'd1);
            last_fall = f.last_fall;
        end
        exp_q.delete();
        rx_q.delete();
        guard = 0;
        while (busy && guard < 500) begin
            step();
            guard++;
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_busy_after_gap"}, {31'd0, (cyc - last_fall) >= CLK_DIV + GAP_CYCLES}, 32'd1);
        chk({tag, "_timing"}, timing_err, 0);
        chk({tag, "_stray"}, stray, 0);
    endtask

    initial begin
        logic [7:0] hold [6];
        logic       rdy, saw_full;
        int         i, guard, s0, st0, ab0;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("idle", {28'd0, ps2_clk, ps2_data, data_ready, busy}, 32'b1110);
        end

        // Single frame with start latency.
        push(8'h1C);
        chk("pre_start", {29'd0, ps2_clk, ps2_data, busy}, 32'b111);
        step();
        chk("start_bit", {30'd0, ps2_clk, ps2_data}, 32'b10);
        drain_check("f1c");

        push(8'h00);
        push(8'hFF);
        push(8'h01);
        drain_check("b2b");

        // Hold data_valid with six bytes so the FIFO fills.
        for (int k = 0; k < 6; k++) hold[k] = 8'($urandom);
        saw_full   = 1'b0;
        i          = 0;
        guard      = 0;
        data_valid = 1'b1;
        while (i < 6 && guard < 2000) begin
            data_in = hold[i];
            rdy     = (occ() < FIFO_DEPTH);
            chk("hold_ready", {31'd0, data_ready}, {31'd0, rdy});
            if (!rdy) saw_full = 1'b1;
            step();
            guard++;
            if (rdy) begin
                exp_q.push_back(hold[i]);
                pushed++;
                i++;
            end
        end
        data_valid = 1'b0;
        chk("hold_all_pushed", i, 6);
        chk("hold_saw_full", {31'd0, saw_full}, 32'd1);
        drain_check("hold");

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 30)) step();
            push(8'($urandom));
        end
        drain_check("rand");

        // Reset in the middle of a frame with another byte still queued.
        push(8'hF0);
        push(8'hAA);
        guard = 0;
        while (nbits < 6 && guard < 500) begin
            step();
            guard++;
        end
        chk("at_bit5", nbits, 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_lines", {28'd0, ps2_clk, ps2_data, data_ready, busy}, 32'b1110);
        exp_q.delete();
        rx_q.delete();
        pushed     = 0;
        start_base = mon_starts;
        s0         = mon_starts;
        st0        = stray;
        for (int k = 0; k < 60; k++) begin
            step();
            chk("post_rst_idle", {28'd0, ps2_clk, ps2_data, data_ready, busy}, 32'b1110);
        end
        chk("post_rst_no_start", mon_starts, s0);
        chk("post_rst_no_edge", stray, st0);
        push(8'h5A);
        drain_check("post_rst");

`ifdef PS2_TX_INHIBIT_EN
        // Inhibit during bit 3 aborts; the byte is resent whole.
        ab0 = aborts;
        push(8'h1C);
        guard = 0;
        while (nbits < 4 && guard < 500) begin
            step();
            guard++;
        end
        host_inhibit = 1'b1;
        step();
        chk("inh_lines", {30'd0, ps2_clk, ps2_data}, 32'b11);
        for (int k = 0; k < 19; k++) begin
            step();
            chk("inh_hold", {29'd0, ps2_clk, ps2_data, busy}, 32'b111);
        end
        host_inhibit = 1'b0;
        drain_check("inh_resend");
        chk("inh_aborted", aborts - ab0, 1);
        pushed     = 0;
        start_base = mon_starts;

        // Inhibit during the stop bit is ignored.
        ab0 = aborts;
        push(8'h1C);
        guard = 0;
        while (nbits < 10 && guard < 500) begin
            step();
            guard++;
        end
        guard = 0;
        while (!ps2_clk && guard < 50) begin
            step();
            guard++;
        end
        host_inhibit = 1'b1;
        repeat (6) step();
        host_inhibit = 1'b0;
        drain_check("inh_stop");
        chk("inh_stop_no_abort", aborts - ab0, 0);
`else
        ab0 = aborts;
        chk("no_aborts", ab0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
